// File: rtl/instruction_prefetch_unit.sv
// Fetch front end: issues sequential word requests, buffers in-order responses in a
// small FIFO and hands {pc, instr} to IF/ID; a redirect flushes and drops stale responses.
module instruction_prefetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          DEPTH        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = PW + 1;
   localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic          req_fire, push, pop;

   // Credit check counts both in-flight requests and buffered words so the FIFO never overflows.
   assign mem_req_valid = !reset && !redirect_valid &&
                          (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_W);
   assign mem_req_addr  = fetch_pc_q;
   assign out_valid     = (count_q != '0);
   assign out_pc        = pc_mem_q[rd_ptr_q];
   assign out_instr     = instr_mem_q[rd_ptr_q];

   always_comb begin
      req_fire   = mem_req_valid && mem_req_ready;
      push       = mem_resp_valid && !redirect_valid && (drop_q == '0);
      pop        = out_valid && out_ready && !redirect_valid;
      outst_d    = outst_q + CW'(req_fire) - CW'(mem_resp_valid);
      drop_d     = drop_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (redirect_valid) begin
         // Everything still in flight (minus this cycle's word) belongs to the old stream.
         drop_d     = outst_q - CW'(mem_resp_valid);
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         resp_pc_d  = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (mem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_VECTOR;
         resp_pc_q  <= RESET_VECTOR;
         outst_q    <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push) begin
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            instr_mem_q[wr_ptr_q] <= mem_resp_data;
         end
      end
   end

   // A response with nothing in flight means the memory side broke the protocol.
   resp_has_credit: assert property (@(posedge clk) disable iff (reset)
                                     mem_resp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Self-checking bench for instruction_prefetch_unit: vector table for reset/stall behaviour,
// a memory model with configurable latency, and a scoreboard of expected {pc, instr} words.
module tb_instruction_prefetch_unit;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic [31:0] out_pc, out_instr;
   logic        out_ready = 1'b0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;

   instruction_prefetch_unit #(.RESET_VECTOR(RV), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct {
      logic rst; logic rdy; logic mrdy;
      logic ev; logic [31:0] epc; logic erv; logic [31:0] eaddr;
   } vec_t;

   pend_t pend_q[$];
   exp_t  exp_q[$];
   vec_t  vecs[$];

   int assertions = 0;
   int failures   = 0;
   int cyc        = 0;
   int lat        = 1;
   int pop_cnt    = 0;
   int waited     = 0;
   logic        rst_cmd = 1'b1, rdy_out = 1'b0, rdy_mem = 1'b1, redir_cmd = 1'b0;
   logic [31:0] redir_pc_cmd = '0;
   logic [31:0] exp_req_pc = RV;
   logic [31:0] first_pop_pc = '0, last_pop_pc = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, then predict what the rising edge does.
   task automatic applyStimulus();
      exp_t e;
      @(negedge clk);
      cyc++;
      reset          = rst_cmd;
      out_ready      = rdy_out;
      mem_req_ready  = rdy_mem;
      redirect_valid = redir_cmd;
      redirect_pc    = redir_pc_cmd;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (rst_cmd) begin
         pend_q.delete();
         exp_q.delete();
         exp_req_pc = RV;
         pop_cnt    = 0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = pend_q[0].addr ^ KEY;
         void'(pend_q.pop_front());
      end
      #1;
      if (!rst_cmd && redir_cmd) begin
         checkOutput("no_req_during_redirect", {31'b0, mem_req_valid}, 32'd0);
         exp_q.delete();
         exp_req_pc = redir_pc_cmd & ~32'd3;
         pop_cnt    = 0;
      end else if (!rst_cmd) begin
         if (mem_req_valid && mem_req_ready) begin
            checkOutput("req_addr_sequence", mem_req_addr, exp_req_pc);
            pend_q.push_back('{mem_req_addr, cyc + lat});
            exp_q.push_back('{exp_req_pc, exp_req_pc ^ KEY});
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (out_valid && out_ready) begin
            assertions++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_pop: got pc %h, expected no output (cycle %0d)", out_pc, cyc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("pop_pc", out_pc, e.pc);
               checkOutput("pop_instr", out_instr, e.instr);
            end
            if (pop_cnt == 0) first_pop_pc = out_pc;
            last_pop_pc = out_pc;
            pop_cnt++;
         end
      end
   endtask

   task automatic addVec(input logic rst, input logic rdy, input logic mrdy, input logic ev,
                         input logic [31:0] epc, input logic erv, input logic [31:0] eaddr);
      vecs.push_back('{rst, rdy, mrdy, ev, epc, erv, eaddr});
   endtask

   task automatic doReset(input int latency);
      lat = latency; rst_cmd = 1'b1; redir_cmd = 1'b0; rdy_out = 1'b1; rdy_mem = 1'b1;
      applyStimulus();
      rst_cmd = 1'b0;
   endtask

   task automatic waitFirstPop(input int budget, input logic [31:0] exp_pc, input string name);
      waited = 0;
      while (pop_cnt == 0 && waited < budget) begin
         applyStimulus();
         waited++;
      end
      checkOutput({name, "_no_timeout"}, {31'b0, pop_cnt != 0}, 32'd1);
      checkOutput({name, "_first_pc"}, first_pop_pc, exp_pc);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state then a streaming run with a 1-cycle memory.
      addVec(1, 1, 1, 0, 32'h0,  0, 32'h0);
      addVec(0, 1, 1, 0, 32'h0,  1, 32'h0);
      addVec(0, 1, 1, 0, 32'h0,  1, 32'h4);
      addVec(0, 1, 1, 1, 32'h0,  1, 32'h8);
      addVec(0, 1, 1, 1, 32'h4,  1, 32'hC);
      addVec(0, 1, 1, 1, 32'h8,  1, 32'h10);
      addVec(0, 1, 1, 1, 32'hC,  1, 32'h14);
      // Consumer stalled for 10 cycles: FIFO fills, requests stop, then drain and resume at 0x10.
      addVec(1, 0, 1, 0, 32'h0,  0, 32'h0);
      addVec(0, 0, 1, 0, 32'h0,  1, 32'h0);
      addVec(0, 0, 1, 0, 32'h0,  1, 32'h4);
      addVec(0, 0, 1, 1, 32'h0,  1, 32'h8);
      addVec(0, 0, 1, 1, 32'h0,  1, 32'hC);
      for (int i = 0; i < 6; i++) addVec(0, 0, 1, 1, 32'h0, 0, 32'h10);
      addVec(0, 1, 1, 1, 32'h0,  0, 32'h10);
      addVec(0, 1, 1, 1, 32'h4,  1, 32'h10);
      addVec(0, 1, 1, 1, 32'h8,  1, 32'h14);
      addVec(0, 1, 1, 1, 32'hC,  1, 32'h18);
      addVec(0, 1, 1, 1, 32'h10, 1, 32'h1C);
      addVec(0, 1, 1, 1, 32'h14, 1, 32'h20);

      lat = 1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst_cmd = vecs[i].rst; rdy_out = vecs[i].rdy; rdy_mem = vecs[i].mrdy; redir_cmd = 1'b0;
         applyStimulus();
         checkOutput("vec_out_valid", {31'b0, out_valid}, {31'b0, vecs[i].ev});
         if (vecs[i].ev) checkOutput("vec_out_pc", out_pc, vecs[i].epc);
         checkOutput("vec_req_valid", {31'b0, mem_req_valid}, {31'b0, vecs[i].erv});
         checkOutput("vec_req_addr", mem_req_addr, vecs[i].eaddr);
      end

      // Redirect with 2 requests in flight and 1 buffered word, 3-cycle memory.
      doReset(3);
      rdy_out = 1'b0;
      repeat (3) applyStimulus();
      rdy_mem = 1'b0;
      applyStimulus();
      redir_cmd = 1'b1; redir_pc_cmd = 32'h100; rdy_out = 1'b1; rdy_mem = 1'b1;
      applyStimulus();
      checkOutput("t3_buffered_before_redirect", {31'b0, out_valid}, 32'd1);
      redir_cmd = 1'b0;
      applyStimulus();
      checkOutput("t3_flushed", {31'b0, out_valid}, 32'd0);
      checkOutput("t3_req_new_pc", mem_req_addr, 32'h100);
      waitFirstPop(12, 32'h100, "t3");
      repeat (6) applyStimulus();

      // Memory not ready for 5 cycles: address held, stream stays contiguous.
      doReset(1);
      repeat (2) applyStimulus();
      rdy_mem = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("t4_req_held_valid", {31'b0, mem_req_valid}, 32'd1);
         checkOutput("t4_req_held_addr", mem_req_addr, 32'h8);
      end
      rdy_mem = 1'b1;
      repeat (10) applyStimulus();
      checkOutput("t4_pop_count", pop_cnt, 32'd10);

      // Redirect colliding with a response and a pop, then a second redirect.
      doReset(1);
      repeat (6) applyStimulus();
      redir_cmd = 1'b1; redir_pc_cmd = 32'h40;
      applyStimulus();
      checkOutput("t5_valid_at_redirect", {31'b0, out_valid}, 32'd1);
      checkOutput("t5_resp_at_redirect", {31'b0, mem_resp_valid}, 32'd1);
      redir_pc_cmd = 32'h80;
      applyStimulus();
      checkOutput("t5_out_valid_after_redirect", {31'b0, out_valid}, 32'd0);
      redir_cmd = 1'b0;
      waitFirstPop(10, 32'h80, "t5");
      checkOutput("t5_redirect_latency", waited, 32'd3);
      repeat (4) applyStimulus();

      // Unaligned redirect near the top of memory: low bits cleared, PC wraps to 0.
      doReset(1);
      repeat (3) applyStimulus();
      redir_cmd = 1'b1; redir_pc_cmd = 32'hFFFF_FFFB;
      applyStimulus();
      redir_cmd = 1'b0;
      waitFirstPop(10, 32'hFFFF_FFF8, "wrap");
      waited = 0;
      while (pop_cnt < 3 && waited < 10) begin
         applyStimulus();
         waited++;
      end
      checkOutput("wrap_third_pop_count", pop_cnt, 32'd3);
      checkOutput("wrap_third_pc", last_pop_pc, 32'h0);

      // Asynchronous reset between clock edges in the middle of a burst.
      doReset(1);
      repeat (6) applyStimulus();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_async_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("t6_async_req_valid", {31'b0, mem_req_valid}, 32'd0);
      checkOutput("t6_async_req_addr", mem_req_addr, RV);
      checkOutput("t6_async_out_pc", out_pc, 32'h0);
      doReset(1);
      applyStimulus();
      checkOutput("t6_restart_addr", mem_req_addr, RV);
      waitFirstPop(6, RV, "t6");
      checkOutput("t6_restart_latency", waited, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
